// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load unit.
//   - load op encodings (req_op)
//   - FSM state enum
//   - access-size, extension-type and legality decode helpers
package load_pkg;

    typedef enum logic [2:0] {
        OpLb      = 3'b000,
        OpLh      = 3'b001,
        OpLw      = 3'b010,
        OpLd      = 3'b011,
        OpLbu     = 3'b100,
        OpLhu     = 3'b101,
        OpLwu     = 3'b110,
        OpIllegal = 3'b111
    } load_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StReqLo,
        StWaitLo,
        StReqHi,
        StWaitHi,
        StResp
    } state_e;

    typedef enum logic {
        ExtZero,
        ExtSign
    } ext_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] op_size(input logic [2:0] op);
        logic [3:0] size;
        case (op[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

    // Bit 2 of the op selects the unsigned variants.
    function automatic ext_e op_ext(input logic [2:0] op);
        return op[2] ? ExtZero : ExtSign;
    endfunction

    // LD and LWU only exist on a 64-bit datapath.
    function automatic logic op_legal(input logic [2:0] op, input int unsigned xlen);
        if (op == OpIllegal) begin
            return 1'b0;
        end
        if ((xlen == 32) && ((op == OpLd) || (op == OpLwu))) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load extractor.
//   data   in  2*XLEN  {hi, lo} memory words (hi = 0 for single-beat accesses)
//   off    in  log2(W) byte offset of the access within lo
//   op     in  3       load op (selects size and sign/zero extension)
//   result out XLEN    extracted and extended load value
module load_align
    import load_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0]         data,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                op,
    output logic [XLEN-1:0]           result
);

    localparam int unsigned W     = XLEN / 8;
    localparam int unsigned IDX_W = $clog2(2 * XLEN);

    logic [IDX_W-1:0] bit_off;
    logic [XLEN-1:0]  window;
    logic [3:0]       size;
    logic             fill;

    assign bit_off = {1'b0, off, 3'b000};

    always_comb begin
        window = data[bit_off +: XLEN];
        size   = op_size(op);
        case (size)
            4'd1:    fill = window[7];
            4'd2:    fill = window[15];
            4'd4:    fill = window[31];
            default: fill = window[XLEN-1];
        endcase
        if (op_ext(op) == ExtZero) begin
            fill = 1'b0;
        end
        // Bytes above the access size take the fill; a full-width load passes through.
        result = window;
        for (int i = 0; i < int'(W); i++) begin
            if (i >= int'(size)) begin
                result[i*8 +: 8] = {8{fill}};
            end
        end
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load unit for the memory stage.
// Accepts one load at a time, issues one or two W-aligned reads, and returns the extended result.
// Build option: MISALIGN_SPLIT_EN -- when defined, word-crossing accesses are split into two
// reads; when undefined they return an access fault without touching memory.
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (req_addr, req_op, req_rd)
//   mem_req_valid/mem_req_ready      memory read request (mem_req_addr, W-aligned)
//   mem_rsp_valid, mem_rsp_data      in-order read data, one pulse per request
//   rsp_valid/rsp_ready              result handshake (rsp_data, rsp_rd, rsp_fault)
//   busy                             high whenever the unit is not idle
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int unsigned W     = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(W);

    state_e            state;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        op_q;
    logic [OFF_W-1:0]  req_off;
    logic              req_cross;
    logic              req_fault;
    logic [2*XLEN-1:0] align_in;
    logic [XLEN-1:0]   align_out;

    assign req_ready = (state == StIdle);
    assign req_off   = req_addr[OFF_W-1:0];
    // Crossing when any byte of the access lies past the end of the aligned word.
    assign req_cross = (int'(req_off) + int'(op_size(req_op))) > int'(W);

`ifdef MISALIGN_SPLIT_EN
    logic            cross_q;
    logic [XLEN-1:0] lo_q;

    assign req_fault = !op_legal(req_op, XLEN);
    // Result is extracted from the word arriving this cycle, so no extra register stage.
    assign align_in  = (state == StWaitHi) ? {mem_rsp_data, lo_q}
                                           : {{XLEN{1'b0}}, mem_rsp_data};
`else
    assign req_fault = !op_legal(req_op, XLEN) || req_cross;
    assign align_in  = {{XLEN{1'b0}}, mem_rsp_data};
`endif

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .data  (align_in),
        .off   (off_q),
        .op    (op_q),
        .result(align_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            off_q         <= '0;
            op_q          <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_rd        <= '0;
            rsp_fault     <= 1'b0;
            busy          <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            cross_q       <= 1'b0;
            lo_q          <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        off_q  <= req_off;
                        op_q   <= req_op;
                        rsp_rd <= req_rd;
                        busy   <= 1'b1;
                        if (req_fault) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state         <= StReqLo;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef MISALIGN_SPLIT_EN
                            cross_q       <= req_cross;
`endif
                        end
                    end
                end
                StReqLo: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (mem_rsp_valid) begin
`ifdef MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            lo_q          <= mem_rsp_data;
                            state         <= StReqHi;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= mem_req_addr + ADDR_W'(W);
                        end else
`endif
                        begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b0;
                            rsp_data  <= align_out;
                        end
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                StReqHi: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (mem_rsp_valid) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_data  <= align_out;
                    end
                end
`endif
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed, table-driven bench for load_unit (XLEN=32, ADDR_W=32).
// Expectations follow whichever build MISALIGN_SPLIT_EN selects.
module tb_load_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_fault;
    logic        busy;

    load_unit #(
        .XLEN  (32),
        .ADDR_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rd       (rsp_rd),
        .rsp_fault    (rsp_fault),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Memory model: one response per accepted request, one cycle later, in order.
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] req_log [$];
    logic        fire       = 1'b0;
    logic [31:0] fire_addr  = '0;
    logic        mute       = 1'b0;
    logic        late_pulse = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            fire      = mem_req_valid && mem_req_ready;
            fire_addr = mem_req_addr;
            if (fire) req_log.push_back(mem_req_addr);
        end
    end

    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #3;
            if (late_pulse) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEADBEEF;
            end else if (fire && !mute) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_rd(fire_addr);
            end else begin
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // Issue one load; returns cycles from acceptance until rsp_valid (bounded) and the result.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] rd,
                            output int lat, output logic [31:0] data, output logic fault,
                            output logic [4:0] rdo, output logic busy_seen);
        @(posedge clk);
        #1;
        req_addr  = addr;
        req_op    = op;
        req_rd    = rd;
        req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        busy_seen = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy_seen = busy;
            if (rsp_valid) break;
        end
        data  = rsp_data;
        fault = rsp_fault;
        rdo   = rsp_rd;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        int          exp_nreq;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat;
        logic [31:0] d;
        logic        f;
        logic [4:0]  r;
        logic        b;
        logic [31:0] base;
        logic [31:0] held_data;
        int          rcyc;
        logic [31:0] rst_addr;
        logic [2:0]  rst_op;

        vecs.push_back('{"lw_aligned", 32'h100, 3'b010, 32'h8899AABB, 32'h0, 32'h8899AABB, 1'b0, 3, 1});
        vecs.push_back('{"lb_sign", 32'h103, 3'b000, 32'h80112233, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1});
        vecs.push_back('{"lbu_zero", 32'h103, 3'b100, 32'h80112233, 32'h0, 32'h00000080, 1'b0, 3, 1});
        vecs.push_back('{"lh_off1", 32'h101, 3'b001, 32'h80112233, 32'h0, 32'h00001122, 1'b0, 3, 1});
        vecs.push_back('{"lh_off2", 32'h102, 3'b001, 32'h80112233, 32'h0, 32'hFFFF8011, 1'b0, 3, 1});
        vecs.push_back('{"lhu_off2", 32'h102, 3'b101, 32'h80112233, 32'h0, 32'h00008011, 1'b0, 3, 1});
        vecs.push_back('{"lb_pos", 32'h200, 3'b000, 32'h0000007F, 32'h0, 32'h0000007F, 1'b0, 3, 1});
        vecs.push_back('{"lw_top", 32'hFFFFFFFC, 3'b010, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 3, 1});
        vecs.push_back('{"op_111", 32'h100, 3'b111, 32'h8899AABB, 32'h0, 32'h0, 1'b1, 1, 0});
        vecs.push_back('{"ld_x32", 32'h100, 3'b011, 32'h8899AABB, 32'h0, 32'h0, 1'b1, 1, 0});
        vecs.push_back('{"lwu_x32", 32'h100, 3'b110, 32'h8899AABB, 32'h0, 32'h0, 1'b1, 1, 0});
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back('{"lh_cross", 32'h103, 3'b001, 32'h34000000, 32'h12, 32'h00001234, 1'b0, 5, 2});
        vecs.push_back('{"lw_cross", 32'h302, 3'b010, 32'hAABBCCDD, 32'h11223344, 32'h3344AABB,
                         1'b0, 5, 2});
        vecs.push_back('{"lw_wrap", 32'hFFFFFFFE, 3'b010, 32'h55667788, 32'h11223344, 32'h33445566,
                         1'b0, 5, 2});
`else
        vecs.push_back('{"lh_cross", 32'h103, 3'b001, 32'h34000000, 32'h12, 32'h0, 1'b1, 1, 0});
        vecs.push_back('{"lw_cross", 32'h302, 3'b010, 32'hAABBCCDD, 32'h11223344, 32'h0, 1'b1, 1, 0});
        vecs.push_back('{"lw_wrap", 32'hFFFFFFFE, 3'b010, 32'h55667788, 32'h11223344, 32'h0,
                         1'b1, 1, 0});
`endif

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_op        = '0;
        req_rd        = '0;
        rsp_ready     = 1'b1;
        mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            base = vecs[i].addr & 32'hFFFFFFFC;
            mem_arr[base]         = vecs[i].lo;
            mem_arr[base + 32'd4] = vecs[i].hi;
            req_log.delete();
            run_load(vecs[i].addr, vecs[i].op, 5'(i + 1), lat, d, f, r, b);
            chk({vecs[i].name, "/data"}, d, vecs[i].exp_data);
            chk({vecs[i].name, "/fault"}, 32'(f), 32'(vecs[i].exp_fault));
            chk({vecs[i].name, "/rd"}, 32'(r), 32'(i + 1));
            chk({vecs[i].name, "/latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "/busy"}, 32'(b), 32'd1);
            chk({vecs[i].name, "/nreq"}, 32'(req_log.size()), 32'(vecs[i].exp_nreq));
            if (vecs[i].exp_nreq >= 1 && req_log.size() >= 1)
                chk({vecs[i].name, "/addr_lo"}, req_log[0], base);
            if (vecs[i].exp_nreq >= 2 && req_log.size() >= 2)
                chk({vecs[i].name, "/addr_hi"}, req_log[1], base + 32'd4);
            @(negedge clk);
            chk({vecs[i].name, "/idle_after"}, 32'({busy, req_ready, rsp_valid}), 32'b010);
        end

        // Back-pressure on both the memory request and the response.
        mem_arr[32'h100] = 32'h8899AABB;
        req_log.delete();
        mem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        req_addr  = 32'h100;
        req_op    = 3'b010;
        req_rd    = 5'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_mem_req_addr", mem_req_addr, 32'h100);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        rsp_ready     = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held_data = rsp_data;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", rsp_data, 32'h8899AABB);
            chk("bp_hold_stable", rsp_data, held_data);
            chk("bp_hold_rd", 32'(rsp_rd), 32'd7);
            chk("bp_hold_fault", 32'(rsp_fault), 32'd0);
            chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_req_ready", 32'(req_ready), 32'd1);
        chk("bp_nreq", 32'(req_log.size()), 32'd1);

        // Reset while waiting on memory, followed by a stray response.
`ifdef MISALIGN_SPLIT_EN
        mem_arr[32'h100] = 32'h34000000;
        mem_arr[32'h104] = 32'h00000012;
        rst_addr = 32'h103;
        rst_op   = 3'b001;
        rcyc     = 3;
`else
        mem_arr[32'h100] = 32'h8899AABB;
        rst_addr = 32'h100;
        rst_op   = 3'b010;
        rcyc     = 1;
`endif
        @(posedge clk);
        #1;
        req_addr  = rst_addr;
        req_op    = rst_op;
        req_rd    = 5'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (rcyc) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        mute = 1'b1;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        late_pulse = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        late_pulse = 1'b0;
        mute       = 1'b0;
        @(negedge clk);
        chk("late_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_busy", 32'(busy), 32'd0);

        mem_arr[32'h100] = 32'h8899AABB;
        req_log.delete();
        run_load(32'h100, 3'b010, 5'd4, lat, d, f, r, b);
        chk("post_rst_data", d, 32'h8899AABB);
        chk("post_rst_fault", 32'(f), 32'd0);
        chk("post_rst_rd", 32'(r), 32'd4);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_nreq", 32'(req_log.size()), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
